// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC block: default geometry, polynomial
// and the controller state encoding.
package crc_pkg;

    localparam int         CRC_WD_DEF = 8;
    localparam logic [7:0] SEED_DEF   = 8'hD8;
    localparam logic [7:0] TAPS_DEF   = 8'h44;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_e;

endpackage

// File: rtl/crc_lfsr_step.sv
// One bit-serial LFSR step: right shift with data-qualified feedback injected
// into the top stage and into every tapped lower stage.
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int                CRC_WD = CRC_WD_DEF,
    parameter logic [CRC_WD-1:0] TAPS   = CRC_WD'(TAPS_DEF)
) (
    input  logic [CRC_WD-1:0] lfsr,
    input  logic              data,
    output logic [CRC_WD-1:0] lfsr_next
);

    logic fb;

    always_comb begin
        fb = lfsr[0] ^ data;
        // The top stage always takes raw feedback, so its tap bit is irrelevant.
        lfsr_next = {fb, lfsr[CRC_WD-1:1] ^ (TAPS[CRC_WD-2:0] & {(CRC_WD-1){fb}})};
    end

endmodule

// File: rtl/crc.sv
// Serial CRC generator: absorbs an LSB-first message while ACTIVE is high,
// then streams the CRC_WD-bit remainder LSB first and reseeds.
module crc
    import crc_pkg::*;
#(
    parameter int                CRC_WD = CRC_WD_DEF,
    parameter logic [CRC_WD-1:0] SEED   = CRC_WD'(SEED_DEF),
    parameter logic [CRC_WD-1:0] TAPS   = CRC_WD'(TAPS_DEF)
) (
    input  logic CLK,
    input  logic RST,
    input  logic ACTIVE,
    input  logic DATA,
    output logic CRC,
    output logic Valid
);

    localparam int CNT_WD = $clog2(CRC_WD + 1);

    state_e              state, state_next;
    logic [CRC_WD-1:0]   lfsr, lfsr_next, lfsr_step;
    logic [CNT_WD-1:0]   cnt, cnt_next;
    logic                crc_next, valid_next;
    logic                last_bit;

    crc_lfsr_step #(
        .CRC_WD (CRC_WD),
        .TAPS   (TAPS)
    ) u_step (
        .lfsr      (lfsr),
        .data      (DATA),
        .lfsr_next (lfsr_step)
    );

    assign last_bit = (cnt == CNT_WD'(CRC_WD));

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            lfsr  <= SEED;
            cnt   <= '0;
            CRC   <= 1'b0;
            Valid <= 1'b0;
        end else begin
            state <= state_next;
            lfsr  <= lfsr_next;
            cnt   <= cnt_next;
            CRC   <= crc_next;
            Valid <= valid_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (ACTIVE)   state_next = ST_SHIFT;
            ST_SHIFT:  if (!ACTIVE)  state_next = ST_OUTPUT;
            ST_OUTPUT: if (last_bit) state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        lfsr_next  = lfsr;
        cnt_next   = cnt;
        crc_next   = CRC;
        valid_next = Valid;
        unique case (state)
            ST_IDLE: begin
                if (ACTIVE) lfsr_next = lfsr_step;
            end
            ST_SHIFT: begin
                if (ACTIVE) begin
                    lfsr_next = lfsr_step;
                end else begin
                    crc_next   = lfsr[0];
                    lfsr_next  = lfsr >> 1;
                    valid_next = 1'b1;
                    cnt_next   = CNT_WD'(1);
                end
            end
            ST_OUTPUT: begin
                // ACTIVE is deliberately ignored until the remainder is out.
                if (last_bit) begin
                    crc_next   = 1'b0;
                    valid_next = 1'b0;
                    lfsr_next  = SEED;
                    cnt_next   = '0;
                end else begin
                    crc_next   = lfsr[0];
                    lfsr_next  = lfsr >> 1;
                    cnt_next   = cnt + CNT_WD'(1);
                end
            end
            default: begin
                lfsr_next  = SEED;
                cnt_next   = '0;
                crc_next   = 1'b0;
                valid_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_crc.sv
// Scoreboard bench for crc: stimulus queues expected CRC words, a negedge
// monitor assembles serial output words and compares them in order.
module tb_crc;
    import crc_pkg::*;

    logic clk = 1'b0;
    logic rst, active, data;
    logic crc_o, valid;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] expq[$];

    crc dut (
        .CLK    (clk),
        .RST    (rst),
        .ACTIVE (active),
        .DATA   (data),
        .CRC    (crc_o),
        .Valid  (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Bit-serial reference: seed 0xD8, taps 0x44, message LSB first.
    function automatic logic [7:0] crc_ref(input logic [7:0] msg, input int n);
        logic [7:0] l, nl;
        logic       fb;
        logic [7:0] taps;
        taps = 8'h44;
        l    = 8'hD8;
        for (int i = 0; i < n; i++) begin
            fb    = l[0] ^ msg[i];
            nl[7] = fb;
            for (int j = 0; j < 7; j++) nl[j] = l[j+1] ^ (taps[j] & fb);
            l = nl;
        end
        return l;
    endfunction

    // Monitor: collect Valid-qualified bits into words, compare against queue.
    int         mon_bits = 0;
    logic [7:0] mon_sh   = '0;
    logic       prev_valid = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            mon_bits   = 0;
            prev_valid = 1'b0;
        end else begin
            if (valid) begin
                mon_sh[mon_bits[2:0]] = crc_o;
                mon_bits++;
                if (mon_bits == 8) begin
                    if (expq.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_crc_word: got 0x%0h, want none", mon_sh);
                    end else begin
                        check("crc_word", 32'(mon_sh), 32'(expq.pop_front()));
                    end
                    mon_bits = 0;
                end
            end else if (prev_valid) begin
                check("valid_len_multiple_of_8", mon_bits, 0);
                check("crc_zero_after_valid", 32'(crc_o), 0);
                mon_bits = 0;
            end
            prev_valid = valid;
        end
    end

    // Drive n message bits; returns #1 after the last absorbing edge.
    task automatic send(input logic [7:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            active = 1'b1;
            data   = m[i];
            @(posedge clk);
            #1;
        end
        active = 1'b0;
        data   = 1'b0;
    endtask

    // Wait for an output phase to finish; optionally hold ACTIVE=1/DATA=1
    // throughout it.
    task automatic wait_done(input logic hold);
        logic seen, done;
        seen = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                seen = 1'b1;
                if (hold) begin
                    active = 1'b1;
                    data   = 1'b1;
                end
            end else if (seen) begin
                done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL output_phase_timeout: got seen=%0b, want completed phase", seen);
        end
        if (hold) begin
            check("idle_after_active_in_output", 32'(dut.state), 32'(ST_IDLE));
            active = 1'b0;
            data   = 1'b0;
        end
        check("lfsr_reseeded", 32'(dut.lfsr), 32'h0000_00D8);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        rst    = 1'b1;
        active = 1'b0;
        data   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(valid), 0);
        check("reset_crc", 32'(crc_o), 0);
        check("reset_lfsr", 32'(dut.lfsr), 32'h0000_00D8);
        check("reset_state", 32'(dut.state), 32'(ST_IDLE));
        rst = 1'b0;

        // Idle hold.
        repeat (3) @(posedge clk);
        #1;
        check("idle_valid", 32'(valid), 0);
        check("idle_lfsr_hold", 32'(dut.lfsr), 32'h0000_00D8);

        // Byte 0x00 and single bit 1.
        expq.push_back(8'h14);
        send(8'h00, 8);
        wait_done(1'b0);
        expq.push_back(8'hA8);
        send(8'h01, 1);
        wait_done(1'b0);

        // Back-to-back 0x00 messages.
        repeat (2) begin
            expq.push_back(8'h14);
            send(8'h00, 8);
            wait_done(1'b0);
        end

        // ACTIVE held high through the output phase, then a clean follow-up.
        expq.push_back(8'h14);
        send(8'h00, 8);
        wait_done(1'b1);
        expq.push_back(8'h14);
        send(8'h00, 8);
        wait_done(1'b0);

        // Reset in the middle of the output phase (no expectation queued).
        send(8'h00, 8);
        for (int c = 0; c < 10 && !valid; c++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("valid_before_abort", 32'(valid), 1);
        check("crc_bit2_before_abort", 32'(crc_o), 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(valid), 0);
        check("async_rst_crc", 32'(crc_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_lfsr", 32'(dut.lfsr), 32'h0000_00D8);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("no_partial_after_abort", 32'(valid), 0);
        end
        expq.push_back(8'h14);
        send(8'h00, 8);
        wait_done(1'b0);

        // Random bytes, each preceded by a reset.
        repeat (10) begin
            pulse_reset();
            b = 8'($urandom);
            expq.push_back(crc_ref(b, 8));
            send(b, 8);
            wait_done(1'b0);
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 32'(expq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/crc.md
CRC -- requirements
Module: crc

Interface
REQ-001 Parameter CRC_WD, default 8, LFSR/CRC width in bits.
REQ-002 Parameter SEED, default 8'hD8, LFSR initial value.
REQ-003 Parameter TAPS, default 8'h44, XOR-tap mask; bit i set means stage i receives feedback.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset; asynchronous, active-high.
REQ-006 ACTIVE  input  1  high means DATA carries a valid message bit this cycle.
REQ-007 DATA  input  1  serial message bit; the message is sent LSB first.
REQ-008 CRC  output  1  serial CRC bit, registered, LSB first.
REQ-009 Valid  output  1  high while CRC carries a valid CRC bit, registered.

Function
REQ-010 The block SHALL have three states: IDLE, SHIFT and OUTPUT.
REQ-011 The LFSR SHALL be CRC_WD bits wide and SHALL hold SEED after reset.
REQ-012 On each rising edge with ACTIVE=1 in IDLE or SHIFT:
- fb = LFSR[0] XOR DATA.
- LFSR[CRC_WD-1] <= fb.
- For i < CRC_WD-1: LFSR[i] <= LFSR[i+1] XOR (TAPS[i] AND fb).
- The state SHALL become SHIFT.
REQ-013 Message length SHALL be arbitrary (one or more bits); the block counts no input bits.
REQ-014 On the first rising edge with ACTIVE=0 in SHIFT, the block SHALL enter OUTPUT:
- CRC <= LFSR[0].
- LFSR <= LFSR >> 1.
- Valid <= 1.
- Bit counter <= 1.
REQ-015 In OUTPUT, each rising edge SHALL present the next bit and shift again until exactly CRC_WD bits have been presented.
- Valid SHALL stay high for exactly CRC_WD consecutive cycles.
- The CRC bit sequence SHALL be the final LFSR value, bit 0 first.
REQ-016 On the edge after the last output bit:
- Valid <= 0 and CRC <= 0.
- LFSR <= SEED.
- The state SHALL return to IDLE.
REQ-017 ACTIVE SHALL be ignored during OUTPUT; no input bit is absorbed until OUTPUT completes.
REQ-018 In IDLE with ACTIVE=0, all registers SHALL hold and Valid SHALL stay 0.
REQ-019 The bit counter SHALL be ceil(log2(CRC_WD+1)) bits wide and SHALL NOT wrap within an output phase.

Reset
REQ-020 RST=1 SHALL immediately, without waiting for a clock edge, set:
- LFSR = SEED.
- CRC = 0 and Valid = 0.
- Counter = 0.
- State = IDLE.
REQ-021 Asserting RST mid-message or mid-output SHALL abort the operation; no partial CRC SHALL be emitted afterwards.
REQ-022 After RST is released, the first rising edge SHALL operate normally.

Structure
REQ-023 The state encoding, CRC_WD, SEED and TAPS defaults SHALL live in a shared package, crc_pkg.
REQ-024 The LFSR next-state logic SHALL be a separate sub-module, crc_lfsr_step (combinational: LFSR, DATA in; next LFSR out).
- It SHALL be instantiated once in crc.
- The FSM, counter and output registers SHALL remain in crc.

Verification
REQ-025 Reset:
- Assert RST while Valid=1 mid-output.
- Valid and CRC drop to 0 asynchronously.
- After release, the LFSR equals 0xD8.
REQ-026 Byte 0x00:
- ACTIVE=1 for 8 cycles with DATA=0, then ACTIVE=0.
- Valid is high for 8 cycles.
- Serial CRC = 0,0,1,0,1,0,0,0 (0x14).
REQ-027 Single bit:
- ACTIVE=1 for 1 cycle with DATA=1, then ACTIVE=0.
- Output is 0xA8: bits 0,0,0,1,0,1,0,1.
REQ-028 Back-to-back messages:
- Send 0x00, wait for Valid to fall, send 0x00 again.
- Both outputs are 0x14, proving the reseed.
REQ-029 ACTIVE during OUTPUT:
- Drive ACTIVE=1 with DATA=1 throughout the 0x00 output phase.
- CRC is still 0x14, and the next state is IDLE.
REQ-030 Random bytes:
- Apply ten random bytes, LSB first, each preceded by a reset.
- Each 8-bit output matches a bit-serial reference model of REQ-012 with seed 0xD8 and taps 0x44.
